// File: rtl/elevator_pkg.sv
// Shared types for the elevator call scheduler: direction codes, FSM states, floor width.
package elevator_pkg;

    localparam int FLOOR_W = 4;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEEK   = 3'd1,
        TRAVEL = 3'd2,
        DWELL  = 3'd3,
        HALT   = 3'd4
    } state_t;

endpackage

// File: rtl/elevator_call_scheduler_floor_pick.sv
// SCAN pick: current floor, else nearest ahead in sweep direction, else nearest behind.
// Purely combinational, no backpressure.
module floor_pick
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 16
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    car_floor,
    input  dir_t                  sweep_dir,
    output logic                  pick_valid,
    output logic [FLOOR_W-1:0]    pick_floor,
    output dir_t                  pick_dir
);

    logic               here;
    logic               up_v;
    logic               dn_v;
    logic [FLOOR_W-1:0] up_f;
    logic [FLOOR_W-1:0] dn_f;

    always_comb begin
        here = 1'b0;
        up_v = 1'b0;
        up_f = '0;
        dn_v = 1'b0;
        dn_f = '0;
        // Descending scan leaves the lowest floor above; ascending leaves the highest below.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (FLOOR_W'(i) > car_floor)) begin
                up_v = 1'b1;
                up_f = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) < car_floor)) begin
                dn_v = 1'b1;
                dn_f = FLOOR_W'(i);
            end
            if (pending[i] && (FLOOR_W'(i) == car_floor)) begin
                here = 1'b1;
            end
        end
    end

    always_comb begin
        pick_valid = 1'b0;
        pick_floor = car_floor;
        if (here) begin
            pick_valid = 1'b1;
        end else if (sweep_dir == DIR_DOWN) begin
            if (dn_v) begin
                pick_valid = 1'b1;
                pick_floor = dn_f;
            end else if (up_v) begin
                pick_valid = 1'b1;
                pick_floor = up_f;
            end
        end else begin
            if (up_v) begin
                pick_valid = 1'b1;
                pick_floor = up_f;
            end else if (dn_v) begin
                pick_valid = 1'b1;
                pick_floor = dn_f;
            end
        end

        if (pick_floor > car_floor) begin
            pick_dir = DIR_UP;
        end else if (pick_floor < car_floor) begin
            pick_dir = DIR_DOWN;
        end else begin
            pick_dir = sweep_dir;
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Latches floor calls and drives one SCAN-ordered target floor with door dwell and emergency halt.
// All outputs registered; SEEK adds one cycle between retire and next target; car is never stalled.
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS       = 16,
    parameter int DOOR_HOLD_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [FLOOR_W-1:0]    car_floor,
    input  logic                  car_door_open,
    input  logic                  emergency,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  target_valid,
    output logic [1:0]            sweep_dir,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  halted
);

    localparam int CNT_W = (DOOR_HOLD_CYCLES > 1) ? $clog2(DOOR_HOLD_CYCLES) : 1;

    state_t                state_q;
    dir_t                  sweep_q;
    logic [FLOOR_W-1:0]    target_q;
    logic                  valid_q;
    logic                  halted_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [NUM_FLOORS-1:0] pending_q;
    logic [NUM_FLOORS-1:0] pending_d;

    logic [NUM_FLOORS-1:0] car_mask;
    logic [NUM_FLOORS-1:0] tgt_mask;
    logic [NUM_FLOORS-1:0] pick_pending;
    logic                  pick_valid;
    logic [FLOOR_W-1:0]    pick_floor;
    dir_t                  pick_dir;
    logic                  retarget;
    logic                  dwell_done;
    logic                  retire;

    always_comb begin
        car_mask = '0;
        tgt_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (FLOOR_W'(i) == car_floor) car_mask[i] = 1'b1;
            if (FLOOR_W'(i) == target_q)  tgt_mask[i] = 1'b1;
        end
    end

    // While travelling the car's own floor is excluded so the pick is the nearest floor strictly ahead.
    assign pick_pending = (state_q == TRAVEL) ? (pending_q & ~car_mask) : pending_q;

    floor_pick #(
        .NUM_FLOORS (NUM_FLOORS)
    ) u_pick (
        .pending    (pick_pending),
        .car_floor  (car_floor),
        .sweep_dir  (sweep_q),
        .pick_valid (pick_valid),
        .pick_floor (pick_floor),
        .pick_dir   (pick_dir)
    );

    always_comb begin
        retarget = 1'b0;
        if (pick_valid && (pick_dir == sweep_q)) begin
            if (sweep_q == DIR_UP) begin
                retarget = (pick_floor > car_floor) && (pick_floor < target_q);
            end else if (sweep_q == DIR_DOWN) begin
                retarget = (pick_floor < car_floor) && (pick_floor > target_q);
            end
        end
    end

    assign dwell_done = (state_q == DWELL) && car_door_open
                        && (cnt_q == CNT_W'(DOOR_HOLD_CYCLES - 1));
    assign retire     = dwell_done && !emergency;
    // A same-cycle call on the floor being retired is dropped: the door is already open there.
    assign pending_d  = (pending_q | call_req) & ~(retire ? tgt_mask : '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sweep_q   <= DIR_NONE;
            target_q  <= '0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            cnt_q     <= '0;
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
            if (emergency) begin
                state_q  <= HALT;
                target_q <= car_floor;
                valid_q  <= 1'b0;
                halted_q <= 1'b1;
                cnt_q    <= '0;
            end else begin
                halted_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        target_q <= car_floor;
                        valid_q  <= 1'b0;
                        sweep_q  <= DIR_NONE;
                        if (|pending_q) state_q <= SEEK;
                    end
                    SEEK: begin
                        if (pick_valid) begin
                            target_q <= pick_floor;
                            valid_q  <= 1'b1;
                            sweep_q  <= pick_dir;
                            state_q  <= TRAVEL;
                        end else begin
                            target_q <= car_floor;
                            valid_q  <= 1'b0;
                            sweep_q  <= DIR_NONE;
                            state_q  <= IDLE;
                        end
                    end
                    TRAVEL: begin
                        if (car_floor == target_q) begin
                            cnt_q   <= '0;
                            state_q <= DWELL;
                        end else if (retarget) begin
                            target_q <= pick_floor;
                        end
                    end
                    DWELL: begin
                        if (car_door_open) begin
                            if (dwell_done) begin
                                cnt_q   <= '0;
                                state_q <= SEEK;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    HALT: begin
                        target_q <= car_floor;
                        state_q  <= SEEK;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign target_floor = target_q;
    assign target_valid = valid_q;
    assign sweep_dir    = sweep_q;
    assign pending      = pending_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler; service order checked against a queue of expected floors.
module tb_elevator_call_scheduler;

    localparam int HOLD = 8;
    // Edge that sees arrival moves TRAVEL->DWELL, then HOLD door-open DWELL cycles until retire.
    localparam int ARRIVE_TO_RETIRE = HOLD + 1;
    localparam logic [1:0] D_NONE = 2'b00;
    localparam logic [1:0] D_UP   = 2'b01;
    localparam logic [1:0] D_DOWN = 2'b10;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] call_req;
    logic [3:0]  car_floor;
    logic        car_door_open;
    logic        emergency;
    logic [3:0]  target_floor;
    logic        target_valid;
    logic [1:0]  sweep_dir;
    logic [15:0] pending;
    logic        halted;

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    elevator_call_scheduler #(
        .NUM_FLOORS       (16),
        .DOOR_HOLD_CYCLES (HOLD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .call_req      (call_req),
        .car_floor     (car_floor),
        .car_door_open (car_door_open),
        .emergency     (emergency),
        .target_floor  (target_floor),
        .target_valid  (target_valid),
        .sweep_dir     (sweep_dir),
        .pending       (pending),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for a freshly pursued target, then compare it with the next expected service.
    task automatic acquire(input string tag, input logic [1:0] dir);
        int n;
        int fl;
        n = 0;
        while (!(target_valid && pending[target_floor]) && n < 30) begin
            cyc(1);
            n++;
        end
        check({tag, "_wait"}, 32'(n < 30), 1);
        fl = -1;
        if (exp_q.size() > 0) fl = exp_q.pop_front();
        check({tag, "_tgt"}, 32'(target_floor), fl);
        check({tag, "_dir"}, 32'(sweep_dir), 32'(dir));
        check({tag, "_vld"}, 32'(target_valid), 1);
    endtask

    // Park the car at fl with the door open (optionally closing it for a gap) and count cycles to retire.
    task automatic dwell(input string tag, input int fl, input int gap_at, input int gap_len,
                         input logic [15:0] last_call, input int exp);
        int n;
        n = 0;
        car_floor     = 4'(fl);
        car_door_open = 1'b1;
        while (pending[fl] && n < 60) begin
            if (n == gap_at) car_door_open = 1'b0;
            if (n == gap_at + gap_len) car_door_open = 1'b1;
            call_req = (n == exp - 1) ? last_call : 16'h0;
            cyc(1);
            n++;
        end
        call_req      = 16'h0;
        car_door_open = 1'b0;
        check({tag, "_retire_cycles"}, n, exp);
    endtask

    initial begin
        int n;
        reset         = 1'b1;
        call_req      = 16'h0;
        car_floor     = 4'd0;
        car_door_open = 1'b0;
        emergency     = 1'b0;
        #1 reset = 1'b0;
        cyc(2);
        check("rst_tgt", 32'(target_floor), 0);
        check("rst_vld", 32'(target_valid), 0);
        check("rst_dir", 32'(sweep_dir), 32'(D_NONE));
        check("rst_pend", 32'(pending), 0);
        check("rst_halt", 32'(halted), 0);
        reset = 1'b1;
        cyc(1);

        // Single call to floor 5 from floor 0.
        call_req = 16'h0020;
        exp_q.push_back(5);
        cyc(1);
        call_req = 16'h0;
        check("t1_latch", 32'(pending), 32'h0020);
        cyc(1);
        check("t1_seek_vld", 32'(target_valid), 0);
        acquire("t1", D_UP);
        dwell("t1", 5, 99, 0, 16'h0, ARRIVE_TO_RETIRE);
        cyc(1);
        check("t1_idle_vld", 32'(target_valid), 0);
        check("t1_idle_dir", 32'(sweep_dir), 32'(D_NONE));
        check("t1_idle_pend", 32'(pending), 0);

        // SCAN: sweep up to 4, then calls {2,7,9} served 7, 9, 2.
        car_floor = 4'd0;
        cyc(1);
        call_req = 16'h0010;
        exp_q.push_back(4);
        cyc(1);
        call_req = 16'h0;
        acquire("s4", D_UP);
        car_floor     = 4'd4;
        car_door_open = 1'b1;
        cyc(1);
        call_req = 16'h0284;
        exp_q.push_back(7);
        exp_q.push_back(9);
        exp_q.push_back(2);
        cyc(1);
        call_req = 16'h0;
        n = 2;
        while (pending[4] && n < 40) begin
            cyc(1);
            n++;
        end
        car_door_open = 1'b0;
        check("s4_retire_cycles", n, ARRIVE_TO_RETIRE);
        acquire("s7", D_UP);
        dwell("s7", 7, 99, 0, 16'h0, ARRIVE_TO_RETIRE);
        acquire("s9", D_UP);
        dwell("s9", 9, 99, 0, 16'h0, ARRIVE_TO_RETIRE);
        check("s9_dir_kept", 32'(sweep_dir), 32'(D_UP));
        acquire("s2", D_DOWN);
        dwell("s2", 2, 99, 0, 16'h0, ARRIVE_TO_RETIRE);
        cyc(1);
        check("s_idle_vld", 32'(target_valid), 0);

        // Retarget: heading 3 -> 9, call 6 appears in between.
        car_floor = 4'd3;
        cyc(1);
        call_req = 16'h0200;
        exp_q.push_back(9);
        cyc(1);
        call_req = 16'h0;
        acquire("r9", D_UP);
        call_req = 16'h0040;
        exp_q.push_back(6);
        exp_q.push_back(9);
        cyc(1);
        call_req = 16'h0;
        check("r_hold", 32'(target_floor), 9);
        cyc(1);
        check("r_retarget", 32'(target_floor), 6);
        check("r_keep9", 32'(pending[9]), 1);
        acquire("r6", D_UP);
        // Door closed 3 cycles mid-dwell; calls on 6 and 1 in the retire cycle.
        dwell("r6", 6, 3, 3, 16'h0042, ARRIVE_TO_RETIRE + 3);
        check("r6_same_floor_drop", 32'(pending), 32'h0202);
        acquire("r9b", D_UP);

        // Emergency during travel at floor 5 toward 9.
        car_floor = 4'd5;
        cyc(1);
        emergency = 1'b1;
        cyc(1);
        check("e_halted", 32'(halted), 1);
        check("e_tgt", 32'(target_floor), 5);
        check("e_vld", 32'(target_valid), 0);
        check("e_pend", 32'(pending), 32'h0202);
        check("e_dir", 32'(sweep_dir), 32'(D_UP));
        call_req = 16'h1000;
        cyc(1);
        call_req = 16'h0;
        check("e_latch", 32'(pending), 32'h1202);
        emergency = 1'b0;
        exp_q.push_back(9);
        cyc(1);
        check("e_release_halt", 32'(halted), 0);
        acquire("e9", D_UP);
        check("sb_drained", exp_q.size(), 0);

        // Asynchronous reset away from any clock edge.
        cyc(1);
        #2 reset = 1'b0;
        #1;
        check("ar_tgt", 32'(target_floor), 0);
        check("ar_vld", 32'(target_valid), 0);
        check("ar_dir", 32'(sweep_dir), 32'(D_NONE));
        check("ar_pend", 32'(pending), 0);
        check("ar_halt", 32'(halted), 0);
        cyc(1);
        reset = 1'b1;
        cyc(3);
        check("ar_after_pend", 32'(pending), 0);
        check("ar_after_vld", 32'(target_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
